// File: rtl/udp_chk_pkg.sv
// Purpose: shared types and constants for the UDP gate-table checker.
// Contents: FSM state enum, gate bit positions inside the 8-bit result, stage-1 record.
// Latency / backpressure: n/a (declarations only).
package udp_chk_pkg;

  // Width of the gate vector and of every result register.
  localparam int RES_W = 8;

  // Bit positions of each gate output inside in_gates (MSB first).
  localparam int GATE_NOT  = 7;
  localparam int GATE_BUF  = 6;
  localparam int GATE_AND  = 5;
  localparam int GATE_OR   = 4;
  localparam int GATE_XOR  = 3;
  localparam int GATE_NAND = 2;
  localparam int GATE_NOR  = 1;
  localparam int GATE_XNOR = 0;

  typedef logic [RES_W-1:0] res_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // One accepted vector as held in stage 1.
  typedef struct packed {
    logic [7:0] idx;
    logic [1:0] src;
    res_t       gates;
  } s1_t;

endpackage

// File: rtl/udp_chk_expect.sv
// Purpose: combinational expected-output table for the upstream UDP stage.
// Ports: src_i {src1, src2} in; exp_o 8-bit expected gate vector out.
// Latency: 0 cycles, pure combinational; no backpressure.
module udp_chk_expect
  import udp_chk_pkg::*;
(
  input  logic [1:0] src_i,
  output res_t       exp_o
);

  logic s1;
  logic s2;

  assign s1 = src_i[1];
  assign s2 = src_i[0];

  always_comb begin
    exp_o            = '0;
    exp_o[GATE_NOT]  = ~s1;
    exp_o[GATE_BUF]  = s1;
    exp_o[GATE_AND]  = s1 & s2;
    exp_o[GATE_OR]   = s1 | s2;
    exp_o[GATE_XOR]  = s1 ^ s2;
    // The upstream UDP table defines its "nand" column with 00 -> 0,
    // which makes it identical to xor; check against that table, not
    // against a textbook nand.
    exp_o[GATE_NAND] = s1 ^ s2;
    exp_o[GATE_NOR]  = ~(s1 | s2);
    exp_o[GATE_XNOR] = ~(s1 ^ s2);
  end

endmodule

// File: rtl/udp_gate_checker.sv
// Purpose: runs NUM_VECTORS vectors from a UDP stage, compares against the gate
//          table, reports pass / saturating error count / first failing vector.
// Ports: clk, rst_n; start; in_valid/in_ready, in_src, in_gates; done, pass,
//        err_count, first_err_idx, first_err_bits.
// Latency: done rises 2 cycles after the final accept (stage 1 register, stage 2 compare).
// Backpressure: in_ready is high only while running; in_valid gaps simply stall.
module udp_gate_checker
  import udp_chk_pkg::*;
#(
  parameter int NUM_VECTORS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_src,
  input  logic [7:0] in_gates,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] first_err_idx,
  output logic [7:0] first_err_bits
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_VECTORS - 1);

  state_e     state_q, state_d;
  logic [7:0] idx_q, idx_d;

  // Stage 1: registered copy of the accepted vector.
  logic       s1_vld_q, s1_vld_d;
  s1_t        s1_q, s1_d;

  // Stage 2 result registers.
  logic [7:0] err_q, err_d;
  logic [7:0] fidx_q, fidx_d;
  res_t       fbits_q, fbits_d;
  logic       cap_q, cap_d;

  res_t       exp_gates;
  res_t       diff_bits;
  logic       accept;
  logic       mismatch;
  logic       enter_run;

  udp_chk_expect u_expect (
    .src_i (s1_q.src),
    .exp_o (exp_gates)
  );

  assign accept    = in_valid & (state_q == RUN);
  assign diff_bits = exp_gates ^ s1_q.gates;
  assign mismatch  = s1_vld_q & (|diff_bits);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    s1_vld_d  = 1'b0;
    s1_d      = s1_q;
    err_d     = err_q;
    fidx_d    = fidx_q;
    fbits_d   = fbits_q;
    cap_d     = cap_q;
    enter_run = 1'b0;

    // Stage 2: fold the vector held in stage 1 into the results.
    if (mismatch) begin
      if (err_q != 8'hFF) begin
        err_d = err_q + 8'd1;
      end
      if (!cap_q) begin
        fidx_d  = s1_q.idx;
        fbits_d = diff_bits;
        cap_d   = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          enter_run = 1'b1;
        end
      end
      RUN: begin
        // start is deliberately not looked at here: a run cannot be restarted.
        if (accept) begin
          s1_vld_d = 1'b1;
          s1_d     = '{idx: idx_q, src: in_src, gates: in_gates};
          if (idx_q == LAST_IDX) begin
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      DRAIN: begin
        // DRAIN is only ever entered with the final vector in stage 1; it
        // retires on this edge, so the pipeline is empty from the next cycle.
        state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d   = RUN;
          enter_run = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Starting a run wipes the previous results. The pipeline is empty in
    // IDLE and DONE, so this never races with a stage-2 update.
    if (enter_run) begin
      idx_d   = '0;
      err_d   = '0;
      fidx_d  = '0;
      fbits_d = '0;
      cap_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
      err_q    <= '0;
      fidx_q   <= '0;
      fbits_q  <= '0;
      cap_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      s1_vld_q <= s1_vld_d;
      s1_q     <= s1_d;
      err_q    <= err_d;
      fidx_q   <= fidx_d;
      fbits_q  <= fbits_d;
      cap_q    <= cap_d;
    end
  end

  // Outputs decode straight from state so reset clears them without a clock.
  assign in_ready       = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign pass           = done & (err_q == 8'd0);
  assign err_count      = err_q;
  assign first_err_idx  = fidx_q;
  assign first_err_bits = fbits_q;

endmodule

// File: tb/tb_udp_gate_checker.sv
module tb_udp_gate_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b;
  logic       in_valid;
  logic [1:0] in_src;
  logic [7:0] in_gates;

  logic       rdy_a, done_a, pass_a;
  logic [7:0] ec_a, fidx_a, fbits_a;
  logic       rdy_b, done_b, pass_b;
  logic [7:0] ec_b, fidx_b, fbits_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] ec;
    logic [7:0] fidx;
    logic [7:0] fbits;
    logic       pass;
    int         cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  udp_gate_checker #(.NUM_VECTORS(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .in_valid(in_valid), .in_ready(rdy_a),
    .in_src(in_src), .in_gates(in_gates), .done(done_a), .pass(pass_a),
    .err_count(ec_a), .first_err_idx(fidx_a), .first_err_bits(fbits_a)
  );

  udp_gate_checker #(.NUM_VECTORS(255)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid), .in_ready(rdy_b),
    .in_src(in_src), .in_gates(in_gates), .done(done_b), .pass(pass_b),
    .err_count(ec_b), .first_err_idx(fidx_b), .first_err_bits(fbits_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Gate table worked out by hand from the rules, one byte per {s1,s2}.
  function automatic logic [7:0] ref_gates(input logic [1:0] src);
    case (src)
      2'b00:   return 8'h83;
      2'b01:   return 8'h9C;
      2'b10:   return 8'h5C;
      default: return 8'h71;
    endcase
  endfunction

  function automatic logic rdy(input int d);
    return (d == 0) ? rdy_a : rdy_b;
  endfunction

  function automatic logic dn(input int d);
    return (d == 0) ? done_a : done_b;
  endfunction

  task automatic set_start(input int d, input logic v);
    if (d == 0) start_a = v; else start_b = v;
  endtask

  // Scoreboard monitors: pop one expected result per rising done.
  logic pd_a = 1'b0;
  logic pd_b = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    check("a_pass_outside_done", {31'd0, pass_a & ~done_a}, 32'd0);
    if (done_a && !pd_a) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q_a.pop_front();
        check("a_err_count", {24'd0, ec_a}, {24'd0, e.ec});
        check("a_first_idx", {24'd0, fidx_a}, {24'd0, e.fidx});
        check("a_first_bits", {24'd0, fbits_a}, {24'd0, e.fbits});
        check("a_pass", {31'd0, pass_a}, {31'd0, e.pass});
        check("a_done_cycle", cyc, e.cyc);
      end
    end
    pd_a = done_a;
  end

  always @(negedge clk) begin
    exp_t e;
    check("b_pass_outside_done", {31'd0, pass_b & ~done_b}, 32'd0);
    if (done_b && !pd_b) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q_b.pop_front();
        check("b_err_count", {24'd0, ec_b}, {24'd0, e.ec});
        check("b_first_idx", {24'd0, fidx_b}, {24'd0, e.fidx});
        check("b_first_bits", {24'd0, fbits_b}, {24'd0, e.fbits});
        check("b_pass", {31'd0, pass_b}, {31'd0, e.pass});
        check("b_done_cycle", cyc, e.cyc);
      end
    end
    pd_b = done_b;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_src   = 2'($urandom);
      in_gates = 8'($urandom);
    end
  endtask

  // Present one vector until accepted; acc_cyc is the cycle of the accept.
  task automatic drive_vec(input int d, input logic [1:0] src, input logic [7:0] g,
                           output int acc_cyc);
    bit got;
    got     = 1'b0;
    acc_cyc = -100;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_src   = src;
      in_gates = g;
      if (rdy(d)) begin
        got     = 1'b1;
        acc_cyc = cyc;
      end
    end
    if (!got) check("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_rdy"},  {rdy_a, done_a, pass_a, rdy_b, done_b, pass_b}, 32'd0);
    check({tag, "_ec"},   {ec_a, ec_b}, 32'd0);
    check({tag, "_fidx"}, {fidx_a, fidx_b}, 32'd0);
    check({tag, "_fbit"}, {fbits_a, fbits_b}, 32'd0);
  endtask

  // errmode: 0 clean, 1 vector 2 bit3 flipped, 2 all inverted, 3 random, 4 first 3 wrong.
  // gapmode: 0 none, 1 random 0..2 idle cycles, 2 two idle cycles per vector.
  task automatic do_run(input int d, input int n, input int errmode, input int gapmode,
                        input bit seq, input bit do_start, input bit mid_start);
    int         errs;
    int         first;
    logic [7:0] fbits;
    logic [1:0] src;
    logic [7:0] g;
    logic [7:0] r;
    int         acc;
    bit         seen;
    exp_t       e;
    errs  = 0;
    first = -1;
    fbits = 8'h00;
    if (do_start) begin
      @(negedge clk);
      in_valid = 1'b0;
      set_start(d, 1'b1);
      @(negedge clk);
      set_start(d, 1'b0);
    end
    for (int i = 0; i < n; i++) begin
      if (gapmode == 1 && i > 0) idle($urandom_range(0, 2));
      if (gapmode == 2 && i > 0) idle(2);
      if (mid_start && i == 1) begin
        @(negedge clk);
        in_valid = 1'b0;
        set_start(d, 1'b1);
      end
      src = seq ? 2'(i) : 2'($urandom_range(0, 3));
      r   = ref_gates(src);
      g   = r;
      case (errmode)
        1: if (i == 2) g = r ^ 8'h08;
        2: g = ~r;
        3: if ($urandom_range(0, 2) == 0) g = r ^ 8'($urandom_range(1, 255));
        4: if (i < 3) g = r ^ 8'($urandom_range(1, 255));
        default: g = r;
      endcase
      if (g != r) begin
        errs++;
        if (first < 0) begin
          first = i;
          fbits = g ^ r;
        end
      end
      drive_vec(d, src, g, acc);
      if (mid_start && i == 1) set_start(d, 1'b0);
      if (i == n - 1) begin
        e.ec    = (errs > 255) ? 8'hFF : 8'(errs);
        e.fidx  = (first < 0) ? 8'h00 : 8'(first);
        e.fbits = fbits;
        e.pass  = (errs == 0);
        e.cyc   = acc + 2;
        if (d == 0) q_a.push_back(e); else q_b.push_back(e);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (dn(d)) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) check("done_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int acc;
    rst_n    = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    in_valid = 1'b0;
    in_src   = 2'b00;
    in_gates = 8'h00;
    #1;
    outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_not_ready", {30'd0, rdy_a, rdy_b}, 32'd0);

    do_run(0, 4, 0, 0, 1'b1, 1'b1, 1'b0);   // clean sequential run
    do_run(0, 4, 1, 0, 1'b1, 1'b1, 1'b0);   // single mismatch on vector 2
    do_run(0, 4, 0, 2, 1'b1, 1'b1, 1'b0);   // valid 1,0,0,1,... gaps
    do_run(0, 4, 3, 1, 1'b0, 1'b1, 1'b1);   // start pulsed mid-run
    repeat (8) do_run(0, 4, 3, 1, 1'b0, 1'b1, 1'b0);

    do_run(1, 255, 2, 0, 1'b0, 1'b1, 1'b0); // every vector wrong
    do_run(1, 255, 3, 1, 1'b0, 1'b1, 1'b0); // random errors and gaps

    // Reset in the middle of a run with results already accumulated.
    @(negedge clk);
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    drive_vec(0, 2'b01, 8'h00, acc);
    drive_vec(0, 2'b10, ref_gates(2'b10), acc);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_errs", {24'd0, ec_a}, 32'd1);
    #2 rst_n = 1'b0;
    #1 outputs_zero("midrun_reset");
    repeat (2) begin
      @(negedge clk);
      outputs_zero("held_reset");
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_idle", {29'd0, rdy_a, done_a, pass_a}, 32'd0);
    end
    do_run(0, 4, 0, 1, 1'b0, 1'b1, 1'b0);

    // Restart from DONE with a dirty result.
    do_run(0, 4, 4, 0, 1'b0, 1'b1, 1'b0);
    check("three_errs", {24'd0, ec_a}, 32'd3);
    @(negedge clk);
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    check("restart_rdy", {30'd0, rdy_a, done_a}, 32'd2);
    check("restart_ec", {8'd0, ec_a, fidx_a, fbits_a}, 32'd0);
    do_run(0, 4, 0, 1, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("queues_drained", q_a.size() + q_b.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
